qed_dup_scheduler: RTL and testbench

Control stage directly upstream of the QED instruction-duplication block; it generates the exec_dup signal that the QED block consumes.
- Counts original instructions accepted into the QED i-cache.
- Switches fetch into duplicate mode on a legal request or when the cache is full.
- Counts duplicates replayed out of the cache.
- Flags a QED check point once originals and duplicates balance.
- Legalises the free (formal-tool driven) duplicate request so exec_dup never violates cache capacity or ordering.

---
 rtl/qed_pkg.sv | 17 +
 rtl/qed_round_counter.sv | 32 +++
 rtl/qed_dup_scheduler.sv | 105 ++++++++++
 tb/tb_qed_dup_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/qed_pkg.sv
// Shared types and constants for the QED duplicate scheduler: FSM state
// encoding, the canonical NOP and default cache sizing.
package qed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ORIG  = 2'd1,
        DUP   = 2'd2,
        CHECK = 2'd3
    } qed_state_e;

    // addi x0,x0,0 -- padding that must never be counted as an original
    localparam logic [31:0] QED_NOP_INST  = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH = 16;
    localparam int          DEFAULT_CNT_W = 5;

endpackage

// File: rtl/qed_round_counter.sv
// Per-round instruction counter with synchronous clear and a look-ahead
// output so the FSM can decide on the value the counter is about to take.
module qed_round_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next
);

    // clear wins over increment so an abort never leaves a stale count
    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/qed_dup_scheduler.sv
// Generates exec_dup for the QED duplication block: counts originals, switches
// to replay on a legal request or a full cache, and flags balanced rounds.
module qed_dup_scheduler
    import qed_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter int          CNT_W    = DEFAULT_CNT_W,
    parameter logic [31:0] NOP_INST = QED_NOP_INST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             stall_IF,
    input  logic             ifu_vld,
    input  logic [31:0]      ifu_qed_instruction,
    input  logic             vld_out,
    input  logic             dup_req,
    output logic             exec_dup,
    output logic [CNT_W-1:0] orig_cnt,
    output logic [CNT_W-1:0] dup_cnt,
    output logic             qed_ready,
    output logic             round_abort,
    output qed_state_e       state_dbg
);

    qed_state_e       state, state_next;
    logic             abort_next;
    logic             acc_orig, acc_dup;
    logic             cnt_clr, orig_inc, dup_inc;
    logic [CNT_W-1:0] orig_cnt_next, dup_cnt_next;

    assign acc_orig = ifu_vld && !stall_IF && (ifu_qed_instruction != NOP_INST);
    assign acc_dup  = vld_out && !stall_IF;

    // Counters only move in their own phase; a duplicate beyond the original
    // count is dropped rather than wrapping the balance check.
    assign cnt_clr  = !ena || (state == CHECK);
    assign orig_inc = (state == ORIG) && acc_orig && (orig_cnt != CNT_W'(DEPTH));
    assign dup_inc  = (state == DUP) && acc_dup && (dup_cnt != orig_cnt);

    qed_round_counter #(.CNT_W(CNT_W)) u_orig_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (orig_inc),
        .cnt      (orig_cnt),
        .cnt_next (orig_cnt_next)
    );

    qed_round_counter #(.CNT_W(CNT_W)) u_dup_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (dup_inc),
        .cnt      (dup_cnt),
        .cnt_next (dup_cnt_next)
    );

    always_comb begin
        state_next = state;
        abort_next = 1'b0;
        if (!ena) begin
            state_next = IDLE;
            abort_next = (state != IDLE) && ((orig_cnt != '0) || (state == DUP));
        end else begin
            case (state)
                IDLE:  state_next = ORIG;
                ORIG: begin
                    if (!stall_IF && ((orig_cnt_next == CNT_W'(DEPTH)) ||
                                      (dup_req && (orig_cnt_next != '0)))) begin
                        state_next = DUP;
                    end
                end
                DUP: begin
                    if (!stall_IF && (dup_cnt_next == orig_cnt)) begin
                        state_next = CHECK;
                    end
                end
                CHECK: state_next = ORIG;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are flopped from state_next so they never glitch on decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            exec_dup    <= 1'b0;
            qed_ready   <= 1'b0;
            round_abort <= 1'b0;
        end else begin
            state       <= state_next;
            exec_dup    <= (state_next == DUP);
            qed_ready   <= (state_next == CHECK);
            round_abort <= abort_next;
        end
    end

    assign state_dbg = state;

    a_no_excess_dup : assert property (@(posedge clk) disable iff (!rst)
        !((state == DUP) && acc_dup && (dup_cnt == orig_cnt)));

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Directed bench for qed_dup_scheduler: hand-computed counter, exec_dup,
// qed_ready and round_abort values across normal, forced, stall and abort cases.
module tb_qed_dup_scheduler;
    import qed_pkg::*;

    localparam int          CNT_W = 5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk;
    logic             rst;
    logic             ena;
    logic             stall_IF;
    logic             ifu_vld;
    logic [31:0]      ifu_qed_instruction;
    logic             vld_out;
    logic             dup_req;
    logic             exec_dup;
    logic [CNT_W-1:0] orig_cnt;
    logic [CNT_W-1:0] dup_cnt;
    logic             qed_ready;
    logic             round_abort;
    qed_state_e       state_dbg;

    int total = 0;
    int bad   = 0;

    qed_dup_scheduler #(.DEPTH(16), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ena                 (ena),
        .stall_IF            (stall_IF),
        .ifu_vld             (ifu_vld),
        .ifu_qed_instruction (ifu_qed_instruction),
        .vld_out             (vld_out),
        .dup_req             (dup_req),
        .exec_dup            (exec_dup),
        .orig_cnt            (orig_cnt),
        .dup_cnt             (dup_cnt),
        .qed_ready           (qed_ready),
        .round_abort         (round_abort),
        .state_dbg           (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_vld             = 1'b0;
        ifu_qed_instruction = 32'h0;
        vld_out             = 1'b0;
        dup_req             = 1'b0;
        stall_IF            = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] inst, input logic req);
        ifu_vld             = 1'b1;
        ifu_qed_instruction = inst;
        dup_req             = req;
        tick();
        idle_inputs();
    endtask

    task automatic replay(input int n);
        for (int i = 0; i < n; i++) begin
            vld_out = 1'b1;
            tick();
        end
        vld_out = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic ed, input int oc, input int dc,
                             input logic qr, input logic ra);
        check({tag, ".exec_dup"},    32'(exec_dup),    32'(ed));
        check({tag, ".orig_cnt"},    32'(orig_cnt),    32'(oc));
        check({tag, ".dup_cnt"},     32'(dup_cnt),     32'(dc));
        check({tag, ".qed_ready"},   32'(qed_ready),   32'(qr));
        check({tag, ".round_abort"}, 32'(round_abort), 32'(ra));
    endtask

    initial begin
        rst = 1'b0;
        ena = 1'b0;
        idle_inputs();
        #12;
        check_all("reset", 1'b0, 0, 0, 1'b0, 1'b0);
        check("reset.state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b1;
        tick();
        check("idle_no_ena.state", 32'(state_dbg), 32'(IDLE));

        // basic round: 3 originals, request on the third, 3 replays
        ena = 1'b1;
        tick();
        check("ena.state", 32'(state_dbg), 32'(ORIG));
        fetch(32'h0000_1111, 1'b0);
        fetch(32'h0000_2222, 1'b0);
        check("basic.orig2", 32'(orig_cnt), 32'd2);
        fetch(32'h0000_3333, 1'b1);
        check_all("basic.dup_entry", 1'b1, 3, 0, 1'b0, 1'b0);
        fetch(32'h0000_4444, 1'b0);
        check("basic.no_orig_in_dup", 32'(orig_cnt), 32'd3);
        replay(2);
        check_all("basic.dup2", 1'b1, 3, 2, 1'b0, 1'b0);
        replay(1);
        check_all("basic.check", 1'b0, 3, 3, 1'b1, 1'b0);
        tick();
        check_all("basic.cleared", 1'b0, 0, 0, 1'b0, 1'b0);
        check("basic.back_orig", 32'(state_dbg), 32'(ORIG));

        // forced switch at full cache
        for (int i = 0; i < 15; i++) fetch(32'h100 + 32'(i), 1'b0);
        check_all("full.orig15", 1'b0, 15, 0, 1'b0, 1'b0);
        fetch(32'h0000_0200, 1'b0);
        check_all("full.forced", 1'b1, 16, 0, 1'b0, 1'b0);
        fetch(32'h0000_0201, 1'b0);
        check("full.no_17th", 32'(orig_cnt), 32'd16);
        replay(15);
        check_all("full.dup15", 1'b1, 16, 15, 1'b0, 1'b0);
        replay(1);
        check_all("full.check", 1'b0, 16, 16, 1'b1, 1'b0);
        tick();
        check_all("full.cleared", 1'b0, 0, 0, 1'b0, 1'b0);

        // request with empty count is ignored; NOPs are not counted
        dup_req = 1'b1;
        tick();
        dup_req = 1'b0;
        check("zero_req.state", 32'(state_dbg), 32'(ORIG));
        check("zero_req.exec_dup", 32'(exec_dup), 32'd0);
        fetch(32'h0000_0A01, 1'b0);
        fetch(NOP, 1'b0);
        fetch(32'h0000_0A02, 1'b0);
        fetch(NOP, 1'b0);
        fetch(32'h0000_0A03, 1'b0);
        fetch(NOP, 1'b0);
        fetch(32'h0000_0A04, 1'b0);
        check("nop.orig4", 32'(orig_cnt), 32'd4);
        fetch(NOP, 1'b1);
        check_all("nop.dup_entry", 1'b1, 4, 0, 1'b0, 1'b0);

        // stall during replay freezes everything
        replay(1);
        check("stall.pre", 32'(dup_cnt), 32'd1);
        stall_IF = 1'b1;
        vld_out  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall.dup_frozen", 32'(dup_cnt), 32'd1);
            check("stall.exec_held", 32'(exec_dup), 32'd1);
        end
        stall_IF = 1'b0;
        tick();
        check("stall.resume", 32'(dup_cnt), 32'd2);
        replay(2);
        check_all("stall.check", 1'b0, 4, 4, 1'b1, 1'b0);
        stall_IF = 1'b1;
        tick();
        stall_IF = 1'b0;
        check("stall.check_not_extended", 32'(qed_ready), 32'd0);
        check("stall.after_check", 32'(state_dbg), 32'(ORIG));

        // ena dropped mid-replay
        for (int i = 0; i < 4; i++) fetch(32'h0000_0B00 + 32'(i), 1'b0);
        fetch(32'h0000_0B04, 1'b1);
        check("abort.orig5", 32'(orig_cnt), 32'd5);
        replay(2);
        check("abort.dup2", 32'(dup_cnt), 32'd2);
        ena      = 1'b0;
        stall_IF = 1'b1;
        tick();
        stall_IF = 1'b0;
        check_all("abort.pulse", 1'b0, 0, 0, 1'b0, 1'b1);
        check("abort.state", 32'(state_dbg), 32'(IDLE));
        tick();
        check("abort.pulse_end", 32'(round_abort), 32'd0);
        ena = 1'b1;
        tick();
        check("abort.reenter", 32'(state_dbg), 32'(ORIG));

        // ena dropped in ORIG with nothing counted: no abort pulse
        ena = 1'b0;
        tick();
        check("quiet_abort.pulse", 32'(round_abort), 32'd0);
        check("quiet_abort.state", 32'(state_dbg), 32'(IDLE));
        ena = 1'b1;
        tick();

        // async reset mid-ORIG
        fetch(32'h0000_0C01, 1'b0);
        fetch(32'h0000_0C02, 1'b0);
        check("rst_orig.pre", 32'(orig_cnt), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_all("rst_orig.async", 1'b0, 0, 0, 1'b0, 1'b0);
        check("rst_orig.state", 32'(state_dbg), 32'(IDLE));
        #3;
        rst = 1'b1;
        tick();
        tick();

        // async reset mid-DUP drops exec_dup without a clock
        fetch(32'h0000_0D01, 1'b1);
        check("rst_dup.pre", 32'(exec_dup), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all("rst_dup.async", 1'b0, 0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
